// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline types for the ID-stage hazard scoreboard.
//   stage_t : per-stage tracking entry {v, rd, we, ld}
//   FWD_*   : forwarding-select encoding for the default 3-deep pipeline
// The register field is sized for up to 256 registers so that the struct
// stays parameter-free; narrower indices are zero-extended into it.
package wisc_pipe_pkg;

  localparam int unsigned RD_MAXW = 8;

  typedef logic [RD_MAXW-1:0] rd_t;

  typedef struct packed {
    logic v;
    rd_t  rd;
    logic we;
    logic ld;
  } stage_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/wisc_hazard_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle.
//   master : ID stage (drives instruction fields, stall_in, flush)
//   slave  : scoreboard (drives stall, fwd_sel, wb_rd/wb_we, stall_count)
interface wisc_hazard_scoreboard_if #(
  parameter int NREG  = 8,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
);
  localparam int AW   = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [AW-1:0]        id_rd;
  logic                 id_rd_we;
  logic                 id_is_load;
  logic                 stall_in;
  logic                 flush;
  logic                 stall;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic [AW-1:0]        wb_rd;
  logic                 wb_we;
  logic [15:0]          stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_rd_we, id_is_load, stall_in, flush,
    input  stall, fwd_sel, wb_rd, wb_we, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_rd_we, id_is_load, stall_in, flush,
    output stall, fwd_sel, wb_rd, wb_we, stall_count
  );
endinterface

// File: rtl/wisc_src_match.sv
// Single-operand youngest-match priority encoder and load-use hazard flag.
//   id_valid_i, used_i : operand is live
//   rs_i               : source register (zero-extended)
//   stage_i            : tracked stages, index 0 = stage 1 (EX)
//   sel_o              : 0 = register file, k = forward from stage k
//   hazard_o           : youngest match is a load not yet forwardable
module wisc_src_match
  import wisc_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = 0,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic            id_valid_i,
  input  logic            used_i,
  input  rd_t             rs_i,
  input  stage_t          stage_i [DEPTH],
  output logic [SELW-1:0] sel_o,
  output logic            hazard_o
);

  logic zero_blk;

  always_comb begin
    sel_o    = '0;
    hazard_o = 1'b0;
    zero_blk = (ZERO_REG != 0) && (rs_i == '0);
    // Walk oldest to youngest so the youngest match overwrites older ones.
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid_i && used_i && !zero_blk &&
          stage_i[k-1].v && stage_i[k-1].we && (stage_i[k-1].rd == rs_i)) begin
        sel_o    = SELW'(k);
        hazard_o = stage_i[k-1].ld && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/wisc_hazard_scoreboard.sv
// ID-stage hazard/forwarding scoreboard. Tracks {v, rd, we, ld} of the
// instructions in the DEPTH stages downstream of ID, raises a RAW stall on
// load-use hazards, reports per-operand forwarding selects and drives the
// register-file write port from the last stage.
//   clk, rst : clock, asynchronous active-low reset
//   sb       : slave side of wisc_hazard_scoreboard_if
// NREG must not exceed 256 (width of the shared rd field).
module wisc_hazard_scoreboard
  import wisc_pipe_pkg::*;
#(
  parameter int NREG       = 8,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  wisc_hazard_scoreboard_if.slave   sb
);

  localparam int AW   = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);

  stage_t               stage_q [DEPTH];
  stage_t               stage_d [DEPTH];
  logic [15:0]          cnt_q, cnt_d;
  logic [NSRC-1:0]      hazard;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wisc_src_match #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .ZERO_REG   (ZERO_REG),
      .SELW       (SELW)
    ) u_match (
      .id_valid_i (sb.id_valid),
      .used_i     (sb.id_rs_used[i]),
      .rs_i       (rd_t'(sb.id_rs[i*AW +: AW])),
      .stage_i    (stage_q),
      .sel_o      (fwd_sel[i*SELW +: SELW]),
      .hazard_o   (hazard[i])
    );
  end

  // A flushed instruction never issues, so it cannot need a stall.
  assign stall = (|hazard) & ~sb.flush;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (!sb.stall_in) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        stage_d[k] = stage_q[k-1];
      end
      if (sb.flush || stall) begin
        stage_d[0] = '0;
      end else begin
        stage_d[0] = '{v: sb.id_valid, rd: rd_t'(sb.id_rd), we: sb.id_rd_we, ld: sb.id_is_load};
      end
      if (stall && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.fwd_sel     = fwd_sel;
  assign sb.wb_rd       = stage_q[DEPTH-1].rd[AW-1:0];
  assign sb.wb_we       = stage_q[DEPTH-1].v & stage_q[DEPTH-1].we;
  assign sb.stall_count = cnt_q;

endmodule

// File: tb/tb_wisc_hazard_scoreboard.sv
module tb_wisc_hazard_scoreboard;
  import wisc_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_z;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wisc_hazard_scoreboard_if #(.NREG(8), .NSRC(2), .DEPTH(3)) sb  ();
  wisc_hazard_scoreboard_if #(.NREG(8), .NSRC(2), .DEPTH(3)) sbz ();

  wisc_hazard_scoreboard #(
    .NREG(8), .DEPTH(3), .NSRC(2), .LOAD_STAGE(2), .ZERO_REG(0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  wisc_hazard_scoreboard #(
    .NREG(8), .DEPTH(3), .NSRC(2), .LOAD_STAGE(2), .ZERO_REG(1)
  ) u_dut_z (
    .clk (clk),
    .rst (rst_z),
    .sb  (sbz)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic z, input logic v, input logic [2:0] rs0, input logic [2:0] rs1,
                     input logic [1:0] used, input logic [2:0] rd, input logic we, input logic ld);
    if (z) begin
      sbz.id_valid = v; sbz.id_rs = {rs1, rs0}; sbz.id_rs_used = used;
      sbz.id_rd = rd; sbz.id_rd_we = we; sbz.id_is_load = ld;
    end else begin
      sb.id_valid = v; sb.id_rs = {rs1, rs0}; sb.id_rs_used = used;
      sb.id_rd = rd; sb.id_rd_we = we; sb.id_is_load = ld;
    end
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_z = 1'b0;
    #2;
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", sb.stall); end
    n_cmp++; if (sb.fwd_sel !== 4'd0) begin n_bad++; $display("FAIL rst_fwd: got %0h want 0", sb.fwd_sel); end
    n_cmp++; if (sb.wb_we !== 1'b0) begin n_bad++; $display("FAIL rst_wb_we: got %0b want 0", sb.wb_we); end
    n_cmp++; if (sb.wb_rd !== 3'd0) begin n_bad++; $display("FAIL rst_wb_rd: got %0d want 0", sb.wb_rd); end
    n_cmp++; if (sb.stall_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", sb.stall_count); end
    @(negedge clk);
    rst = 1'b1; rst_z = 1'b1;
    cyc();
  endtask

  task automatic test_fwd_ex();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0);
    cyc();
    put(1'b0, 1'b1, 3'd3, 3'd0, 2'b01, 3'd4, 1'b1, 1'b0);
    #1;
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_EX) begin n_bad++; $display("FAIL fwd_ex: got %0d want 1", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL fwd_ex_stall: got %0b want 0", sb.stall); end
    sb.id_valid = 1'b0;
    #1;
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_RF) begin n_bad++; $display("FAIL fwd_invalid_id: got %0d want 0", sb.fwd_sel[1:0]); end
    sb.id_valid = 1'b1;
    cyc();
    n_cmp++; if (sb.wb_we !== 1'b0) begin n_bad++; $display("FAIL fwd_wb_we0: got %0b want 0", sb.wb_we); end
    put(1'b0, 1'b1, 3'd3, 3'd4, 2'b11, 3'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_MEM) begin n_bad++; $display("FAIL fwd_mem_r3: got %0d want 2", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.fwd_sel[3:2] !== FWD_EX) begin n_bad++; $display("FAIL fwd_ex_r4: got %0d want 1", sb.fwd_sel[3:2]); end
    cyc();
    n_cmp++; if (sb.wb_we !== 1'b1) begin n_bad++; $display("FAIL fwd_wb_we1: got %0b want 1", sb.wb_we); end
    n_cmp++; if (sb.wb_rd !== 3'd3) begin n_bad++; $display("FAIL fwd_wb_rd: got %0d want 3", sb.wb_rd); end
    idle();
  endtask

  task automatic test_load_use();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1);
    cyc();
    put(1'b0, 1'b1, 3'd2, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0);
    #1;
    n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0b want 1", sb.stall); end
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_EX) begin n_bad++; $display("FAIL lu_fwd_during: got %0d want 1", sb.fwd_sel[1:0]); end
    cyc();
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_after: got %0b want 0", sb.stall); end
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_MEM) begin n_bad++; $display("FAIL lu_fwd_after: got %0d want 2", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.stall_count !== 16'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", sb.stall_count); end
    cyc();
    idle();
  endtask

  task automatic test_youngest();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b1);
    cyc();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd7, 1'b0, 1'b0);
    cyc();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
    cyc();
    put(1'b0, 1'b1, 3'd5, 3'd7, 2'b11, 3'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_EX) begin n_bad++; $display("FAIL young_fwd: got %0d want 1", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.fwd_sel[3:2] !== FWD_RF) begin n_bad++; $display("FAIL young_nowe: got %0d want 0", sb.fwd_sel[3:2]); end
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL young_stall: got %0b want 0", sb.stall); end
    n_cmp++; if (sb.wb_rd !== 3'd5) begin n_bad++; $display("FAIL young_wb_rd: got %0d want 5", sb.wb_rd); end
    idle();
  endtask

  task automatic test_stall_in();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b1);
    cyc();
    put(1'b0, 1'b1, 3'd6, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);
    sb.stall_in = 1'b1;
    #1;
    n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL si_stall0: got %0b want 1", sb.stall); end
    repeat (4) cyc();
    n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL si_stall4: got %0b want 1", sb.stall); end
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_EX) begin n_bad++; $display("FAIL si_frozen_fwd: got %0d want 1", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.stall_count !== 16'd1) begin n_bad++; $display("FAIL si_count_held: got %0d want 1", sb.stall_count); end
    sb.stall_in = 1'b0;
    #1;
    n_cmp++; if (sb.stall !== 1'b1) begin n_bad++; $display("FAIL si_stall_rel: got %0b want 1", sb.stall); end
    cyc();
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL si_stall_done: got %0b want 0", sb.stall); end
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_MEM) begin n_bad++; $display("FAIL si_fwd_done: got %0d want 2", sb.fwd_sel[1:0]); end
    n_cmp++; if (sb.stall_count !== 16'd2) begin n_bad++; $display("FAIL si_count: got %0d want 2", sb.stall_count); end
    cyc();
    idle();
  endtask

  task automatic test_flush();
    put(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b1);
    cyc();
    put(1'b0, 1'b1, 3'd1, 3'd0, 2'b01, 3'd4, 1'b1, 1'b0);
    sb.flush = 1'b1;
    #1;
    n_cmp++; if (sb.stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall: got %0b want 0", sb.stall); end
    n_cmp++; if (sb.fwd_sel[1:0] !== FWD_EX) begin n_bad++; $display("FAIL fl_fwd: got %0d want 1", sb.fwd_sel[1:0]); end
    cyc();
    sb.flush = 1'b0;
    put(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (sb.stall_count !== 16'd2) begin n_bad++; $display("FAIL fl_count: got %0d want 2", sb.stall_count); end
    cyc();
    n_cmp++; if (sb.wb_we !== 1'b1) begin n_bad++; $display("FAIL fl_ld_wb_we: got %0b want 1", sb.wb_we); end
    n_cmp++; if (sb.wb_rd !== 3'd1) begin n_bad++; $display("FAIL fl_ld_wb_rd: got %0d want 1", sb.wb_rd); end
    cyc();
    n_cmp++; if (sb.wb_we !== 1'b0) begin n_bad++; $display("FAIL fl_bubble_wb_we: got %0b want 0", sb.wb_we); end
    idle();
  endtask

  task automatic test_zero_reg();
    put(1'b1, 1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1);
    cyc();
    put(1'b1, 1'b1, 3'd0, 3'd0, 2'b01, 3'd3, 1'b1, 1'b1);
    #1;
    n_cmp++; if (sbz.fwd_sel[1:0] !== FWD_RF) begin n_bad++; $display("FAIL zr_fwd: got %0d want 0", sbz.fwd_sel[1:0]); end
    n_cmp++; if (sbz.stall !== 1'b0) begin n_bad++; $display("FAIL zr_stall: got %0b want 0", sbz.stall); end
    cyc();
    put(1'b1, 1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (sbz.stall !== 1'b1) begin n_bad++; $display("FAIL zr_nz_stall: got %0b want 1", sbz.stall); end
    cyc();
    n_cmp++; if (sbz.stall_count !== 16'd1) begin n_bad++; $display("FAIL zr_count: got %0d want 1", sbz.stall_count); end
    n_cmp++; if (sbz.wb_we !== 1'b1) begin n_bad++; $display("FAIL zr_wb_we: got %0b want 1", sbz.wb_we); end
    n_cmp++; if (sbz.fwd_sel[1:0] !== FWD_MEM) begin n_bad++; $display("FAIL zr_fwd_mem: got %0d want 2", sbz.fwd_sel[1:0]); end
    #2;
    rst_z = 1'b0;
    #1;
    n_cmp++; if (sbz.stall_count !== 16'd0) begin n_bad++; $display("FAIL zr_arst_count: got %0d want 0", sbz.stall_count); end
    n_cmp++; if (sbz.wb_we !== 1'b0) begin n_bad++; $display("FAIL zr_arst_wb_we: got %0b want 0", sbz.wb_we); end
    n_cmp++; if (sbz.fwd_sel !== 4'd0) begin n_bad++; $display("FAIL zr_arst_fwd: got %0h want 0", sbz.fwd_sel); end
    n_cmp++; if (sbz.stall !== 1'b0) begin n_bad++; $display("FAIL zr_arst_stall: got %0b want 0", sbz.stall); end
  endtask

  initial begin
    put(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
    sb.stall_in = 1'b0; sb.flush = 1'b0;
    sbz.stall_in = 1'b0; sbz.flush = 1'b0;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_youngest();
    test_stall_in();
    test_flush();
    test_zero_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wisc_hazard_scoreboard.md
Name: wisc_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit that sits in the ID stage.
- Tracks the destination registers of in-flight instructions across DEPTH downstream stages.
- For each of NSRC source operands it produces a RAW stall and a forwarding select.
- Also supplies the write-back register address and enable to the register file.
- Generalises the fixed 3-deep, 2-source, 8-register hazard logic to configurable depth, source count, register count, load latency and zero-register mode.

Parameters:
NREG, 8, number of architectural registers
AW, $clog2(NREG), register index width (derived)
DEPTH, 3, tracked stages downstream of ID (stage 1 = EX, stage DEPTH = WB)
NSRC, 2, source operands checked per instruction
LOAD_STAGE, 2, first stage whose load result can be forwarded
ZERO_REG, 0, if 1 then register 0 never creates a hazard
SELW, $clog2(DEPTH+1), forwarding select width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs  in  NSRC*AW  source register indices, operand i at [i*AW +: AW]
id_rs_used  in  NSRC  operand i is actually read
id_rd  in  AW  destination register
id_rd_we  in  1  instruction writes id_rd
id_is_load  in  1  instruction is a load
stall_in  in  1  external freeze (cache miss); holds every stage
flush  in  1  kill the instruction in ID (taken branch/jump/exception)
stall  out  1  RAW stall request to fetch/ID
fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = forward from stage k
wb_rd  out  AW  register-file write address (stage DEPTH)
wb_we  out  1  register-file write enable (stage DEPTH valid & we)
stall_count  out  16  saturating count of cycles with stall=1

Behaviour:
- Each stage k (1..DEPTH) holds the state {v, rd, we, ld}.
- Reset (rst=0, asynchronous): all v=0, rd=0, we=0, ld=0, stall_count=0. Consequently stall=0, fwd_sel=0, wb_we=0 and wb_rd=0.
- Match for operand i at stage k: id_valid & id_rs_used[i] & v_k & we_k & (rd_k==rs_i) & ~(ZERO_REG & rs_i==0).
- Operand i selects the youngest matching stage (smallest k). fwd_sel_i = k, or 0 if no stage matches.
- Operand i is hazardous if its youngest match has ld_k=1 and k < LOAD_STAGE.
- Older matches behind a younger match are ignored; the younger value supersedes them.
- stall = OR over operands of hazardous, gated by ~flush. stall is combinational from stage registers and ID inputs.
- fwd_sel is don't-care while stall=1, but must still equal the youngest-match encoding.
- Clock edge, priority highest first:
  1. stall_in=1: all stages hold; stall_count unchanged.
  2. flush=1: stage 1 gets a bubble (v=0); stages 2..DEPTH shift from k-1.
  3. stall=1: stage 1 gets a bubble; the others shift; the ID instruction is re-presented next cycle.
  4. Otherwise: stage 1 <= {id_valid, id_rd, id_rd_we, id_is_load}; the others shift.
- stall_count increments on every edge where stall=1 and stall_in=0. It saturates at 16'hFFFF.
- wb_we and wb_rd are driven straight from stage DEPTH. The register file bypasses same-cycle writes, so forwarding from stage DEPTH is still reported but is functionally redundant.
- A reset asserted mid-operation clears all tracked state immediately; in-flight writes are lost.
- Simultaneous flush and hazard: flush wins and stall=0.
- A stall_in with a pending hazard keeps stall asserted; state is frozen until stall_in drops.
- Instructions with id_rd_we=0 (stores, branches) never create a match.

Decomposition:
- Shared package wisc_pipe_pkg holds:
  - the stage-entry struct {v, rd, we, ld};
  - the fwd_sel encoding constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3 for the default depth.
- Sub-module wisc_src_match (one per operand, generate loop) does the youngest-match priority encode and the load-use hazard flag for a single operand.

Test Plan:
- Reset, then ADD r3 followed by ADD using rs=r3 (default params) -> fwd_sel[0]=1, stall=0; one cycle later wb_we=0 and stage 2 holds r3.
- LD r2 followed immediately by a consumer of r2 -> stall=1 for exactly 1 cycle, stall_count=1. Next cycle fwd_sel=2 and stall=0.
- Two writers of r5 in stages 1 and 3, consumer reads r5 -> fwd_sel=1 (youngest wins).
- Load-use hazard with stall_in=1 held for 4 cycles -> stall stays 1, stages frozen, stall_count unchanged. After release: one stall cycle, then forward.
- flush=1 coincident with a load-use hazard -> stall=0; stage 1 gets a bubble; wb_we for the flushed slot is 0 DEPTH cycles later.
- ZERO_REG=1, writer of r0 then reader of r0 -> fwd_sel=0, stall=0. Then assert rst=0 mid-stream -> all outputs 0 asynchronously.
